// File: rtl/dcache_pkg.sv
// Shared constants, address layout and FSM encoding for the direct-mapped L1 data cache.
package dcache_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned LINES   = 32;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned OFF_W   = 5;
  localparam int unsigned WSEL_W  = 3;
  localparam int unsigned LINE_W  = 256;
  localparam int unsigned TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned BITSEL_W = 8;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] word;
    logic [1:0]        bsel;
  } cpu_addr_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, OFF_W'(0)};
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Per-line valid/dirty/tag store: async clear of valid/dirty, combinational read,
// a set-dirty port for store hits and a refill port that installs a clean line.
module dcache_tag_array
  import dcache_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_c,
  output logic             rd_dirty_c,
  output logic [TAG_W-1:0] rd_tag_c,
  input  logic             set_dirty_i,
  input  logic [IDX_W-1:0] set_dirty_idx_i,
  input  logic             refill_i,
  input  logic [IDX_W-1:0] refill_idx_i,
  input  logic [TAG_W-1:0] refill_tag_i
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];

  assign rd_valid_c = valid_q[rd_idx_i];
  assign rd_dirty_c = dirty_q[rd_idx_i];
  assign rd_tag_c   = tag_q[rd_idx_i];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (set_dirty_i) dirty_d[set_dirty_idx_i] = 1'b1;
    if (refill_i) begin
      valid_d[refill_idx_i] = 1'b1;
      dirty_d[refill_idx_i] = 1'b0;
      tag_d[refill_idx_i]   = refill_tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tags are only meaningful under valid, so they carry no reset.
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller with external data SRAM.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_wdata_i,
  output logic [WORD_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
`ifdef DCACHE_STATS_EN
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o,
`endif
  output logic              data_enable_o,
  output logic              data_write_o,
  output logic [IDX_W-1:0]  data_addr_o,
  output logic [LINE_W-1:0] data_wdata_o,
  input  logic [LINE_W-1:0] data_rdata_i
);

  cpu_addr_t         cpu_addr;
  state_e            state_q, state_d;
  logic              tag_valid, tag_dirty;
  logic [TAG_W-1:0]  tag_rd;
  logic              hit_c, miss_c, set_dirty_c, refill_c;
  logic [BITSEL_W-1:0] word_lsb;
  logic [LINE_W-1:0] store_line;
  logic              unused_bsel;

  assign cpu_addr    = cpu_addr_t'(cpu_addr_i);
  assign unused_bsel = ^cpu_addr.bsel;
  assign word_lsb    = {cpu_addr.word, 5'd0};

  assign hit_c       = (state_q == IDLE) & cpu_req_i & tag_valid & (tag_rd == cpu_addr.tag);
  assign miss_c      = (state_q == IDLE) & cpu_req_i & ~hit_c;
  assign set_dirty_c = hit_c & cpu_we_i;
  assign refill_c    = (state_q == ALLOCATE) & mem_ack_i;

  dcache_tag_array u_tags (
    .clk_i           (clk_i),
    .rst_ni          (rst_i),
    .rd_idx_i        (cpu_addr.idx),
    .rd_valid_c      (tag_valid),
    .rd_dirty_c      (tag_dirty),
    .rd_tag_c        (tag_rd),
    .set_dirty_i     (set_dirty_c),
    .set_dirty_idx_i (cpu_addr.idx),
    .refill_i        (refill_c),
    .refill_idx_i    (cpu_addr.idx),
    .refill_tag_i    (cpu_addr.tag)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (miss_c) state_d = (tag_valid & tag_dirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ack_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Hits are answered in the same cycle; misses hold the CPU until the retry hits.
  always_comb begin
    cpu_rdata_o   = '0;
    cpu_stall_o   = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    data_enable_o = cpu_req_i | (state_q != IDLE);
    data_write_o  = 1'b0;
    data_addr_o   = cpu_addr.idx;
    data_wdata_o  = '0;
    store_line    = data_rdata_i;
    store_line[word_lsb +: WORD_W] = cpu_wdata_i;
    unique case (state_q)
      IDLE: begin
        cpu_stall_o = miss_c;
        if (hit_c && !cpu_we_i) cpu_rdata_o = data_rdata_i[word_lsb +: WORD_W];
        if (set_dirty_c) begin
          data_write_o = 1'b1;
          data_wdata_o = store_line;
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = line_addr(tag_rd, cpu_addr.idx);
        mem_wdata_o = data_rdata_i;
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = line_addr(cpu_addr.tag, cpu_addr.idx);
        if (refill_c) begin
          data_write_o = 1'b1;
          data_wdata_o = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic             retry_q, retry_d;

  // retry_q marks an access that already missed so its post-refill hit is not counted.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    retry_d    = retry_q;
    if (miss_c) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
      retry_d    = 1'b1;
    end
    if (hit_c) begin
      if (!retry_q) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      retry_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      retry_q    <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      retry_q    <= retry_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: models main memory and the data SRAM,
// queues expected load data and memory transactions, compares as the DUT produces them.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic         data_enable, data_write;
  logic [4:0]   data_addr;
  logic [255:0] data_wdata, data_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .cpu_req_i     (cpu_req),
    .cpu_we_i      (cpu_we),
    .cpu_addr_i    (cpu_addr),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_rdata_o   (cpu_rdata),
    .cpu_stall_o   (cpu_stall),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .mem_ack_i     (mem_ack),
`ifdef DCACHE_STATS_EN
    .hit_cnt_o     (hit_cnt),
    .miss_cnt_o    (miss_cnt),
`endif
    .data_enable_o (data_enable),
    .data_write_o  (data_write),
    .data_addr_o   (data_addr),
    .data_wdata_o  (data_wdata),
    .data_rdata_i  (data_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cache data SRAM: combinational read, write on posedge.
  logic [255:0] sram [32];
  assign data_rdata = sram[data_addr];
  always @(posedge clk) if (data_enable && data_write) sram[data_addr] <= data_wdata;

  // Main memory contents and the architectural view the CPU should observe.
  logic [255:0] mem     [logic [31:0]];
  logic [31:0]  ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_word(la + 32'(w*4));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem.exists(la)) return mem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w*4));
    return l;
  endfunction

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } txn_t;

  txn_t        exp_txn [$];
  logic [31:0] exp_rd  [$];

  task automatic expect_txn(input logic we, input logic [31:0] addr, input logic [255:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    exp_txn.push_back(t);
  endtask

  // Memory responder: checks each new request against the queue, checks it is held, acks after mem_lat.
  int           mem_lat = 2;
  int           lat_cnt = 0;
  logic [31:0]  hold_addr;
  logic         hold_we;
  txn_t         cur;
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (lat_cnt == 0) begin
        hold_addr = mem_addr;
        hold_we   = mem_we;
        if (exp_txn.size() == 0) begin
          check("mem_unexpected_addr", mem_addr, 32'hFFFF_FFFF);
        end else begin
          cur = exp_txn.pop_front();
          check("mem_we", mem_we, cur.we);
          check("mem_addr", mem_addr, cur.addr);
          if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        end
      end else begin
        check("mem_addr_hold", mem_addr, hold_addr);
        check("mem_we_hold", mem_we, hold_we);
        check("stall_hold", cpu_stall, 1'b1);
      end
      if (lat_cnt >= mem_lat) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem_line(mem_addr);
        mem_ack = 1'b1;
        lat_cnt = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  task automatic cpu_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    if (we) ref_mem[{addr[31:2], 2'b00}] = wdata;
    else    exp_rd.push_back(ref_word(addr));
  endtask

  // Wait for the access to complete (stall low), compare its result, then drop the request.
  task automatic cpu_wait(input string tag, output int stalls);
    stalls = 0;
    @(negedge clk);
    while (cpu_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (cpu_stall) begin
      check({tag, "_timeout"}, cpu_stall, 1'b0);
      if (!cpu_we) void'(exp_rd.pop_front());
    end else if (!cpu_we) begin
      check({tag, "_rdata"}, cpu_rdata, exp_rd.pop_front());
    end else begin
      check({tag, "_store_write"}, data_write, 1'b1);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int st;
    int n;
    for (int i = 0; i < 32; i++) sram[i] = '0;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_data_en", data_enable, 1'b0);
    check("rst_data_wr", data_write, 1'b0);
`ifdef DCACHE_STATS_EN
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: cold load miss on a clean line -> allocate only
    expect_txn(1'b0, 32'h0000_0040, '0);
    cpu_issue(1'b0, 32'h0000_0040, '0);
    #1 check("t1_stall_comb", cpu_stall, 1'b1);
    cpu_wait("t1", st);
    check("t1_mem_req_dropped", mem_req, 1'b0);

    // 2: store hit, then read it back
    cpu_issue(1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
    cpu_wait("t2_st", st);
    check("t2_store_nostall", st, 0);
    check("t2_sram_word1", sram[2][63:32], 32'hDEAD_BEEF);
    cpu_issue(1'b0, 32'h0000_0044, '0);
    cpu_wait("t2_ld", st);
    check("t2_load_nostall", st, 0);

    // 3: conflicting tag on dirty line -> write-back of updated line, then allocate
    expect_txn(1'b1, 32'h0000_0040, ref_line(32'h0000_0040));
    expect_txn(1'b0, 32'h0000_0440, '0);
    cpu_issue(1'b0, 32'h0000_0440, '0);
    cpu_wait("t3", st);
`ifdef DCACHE_STATS_EN
    check("t6_miss_cnt", miss_cnt, 32'd2);
    check("t6_hit_cnt", hit_cnt, 32'd2);
`endif
    // refilled line is clean: evicting it needs no write-back; memory holds the stored word
    expect_txn(1'b0, 32'h0000_0040, '0);
    cpu_issue(1'b0, 32'h0000_0044, '0);
    cpu_wait("t3_clean_evict", st);

    // 4: slow memory, request held stable for 20 cycles
    mem_lat = 20;
    expect_txn(1'b0, 32'h0000_0800, '0);
    cpu_issue(1'b0, 32'h0000_0800, '0);
    cpu_wait("t4", st);
    check("t4_stall_len_ok", (st >= 20), 1'b1);
    mem_lat = 2;

    // 5: reset during write-back
    cpu_issue(1'b1, 32'h0000_0040, 32'h1234_5678);
    cpu_wait("t5_st", st);
    mem_lat = 1000;
    expect_txn(1'b1, 32'h0000_0040, ref_line(32'h0000_0040));
    cpu_issue(1'b0, 32'h0000_0440, '0);
    n = 0;
    while (!(mem_req && mem_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_writeback", mem_req & mem_we, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; cpu_req = 1'b0;
    void'(exp_rd.pop_back());
    #1;
    check("t5_rst_mem_req", mem_req, 1'b0);
    check("t5_rst_stall", cpu_stall, 1'b0);
    check("t5_rst_data_en", data_enable, 1'b0);
`ifdef DCACHE_STATS_EN
    check("t5_rst_hit_cnt", hit_cnt, 32'd0);
    check("t5_rst_miss_cnt", miss_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1; mem_lat = 2;
    expect_txn(1'b0, 32'h0000_0440, '0);
    cpu_issue(1'b0, 32'h0000_0440, '0);
    #1 check("t5_post_rst_miss", cpu_stall, 1'b1);
    cpu_wait("t5_ld", st);

    repeat (3) @(posedge clk);
    check("txn_queue_drained", exp_txn.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
